// File: rtl/atmega_eep_pkg.sv
// Shared types for the EEPROM external-port arbiter: FSM state encoding and latched request.
package atmega_eep_pkg;

    localparam int unsigned EEP_ADDR_W = 17;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StRdCap,
        StWr,
        StGap
    } eep_state_e;

    typedef struct packed {
        logic                  we;
        logic [EEP_ADDR_W-1:0] addr;
        logic [7:0]            wdata;
    } eep_req_t;

endpackage

// File: rtl/eep_rr_arb2.sv
// Two-way request picker: fixed priority (req0 wins) or round-robin preferring the
// requester that was not served last. Pointer advances only on a completed transaction.
module eep_rr_arb2
    import atmega_eep_pkg::*;
#(
    parameter int unsigned PRIO_FIX = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_served,
    output logic       o_vld,
    output logic       o_idx
);

    logic r_last;

    // Reset value 1 makes req0 the preferred requester on the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_upd) begin
            r_last <= i_served;
        end
    end

    always_comb begin
        o_vld = |i_req;
        if (PRIO_FIX != 0) begin
            o_idx = ~i_req[0];
        end else if (&i_req) begin
            o_idx = ~r_last;
        end else begin
            o_idx = i_req[1];
        end
    end

endmodule

// File: rtl/atmega_eep_ext_arb.sv
// Arbiter/sequencer sharing the EEPROM external access port between two requesters.
// All port outputs are registered; new grants are withheld while the CPU path is busy.
module atmega_eep_ext_arb
    import atmega_eep_pkg::*;
#(
    parameter int unsigned ADDR_W   = EEP_ADDR_W,
    parameter int unsigned WR_GAP   = 4,
    parameter int unsigned PRIO_FIX = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_rq_req,
    input  logic [1:0]        i_rq_we,
    input  logic [ADDR_W-1:0] i_rq_addr0,
    input  logic [ADDR_W-1:0] i_rq_addr1,
    input  logic [7:0]        i_rq_wdata0,
    input  logic [7:0]        i_rq_wdata1,
    output logic [1:0]        o_rq_gnt,
    output logic [1:0]        o_rq_ack,
    output logic [7:0]        o_rq_rdata,
    input  logic              i_cpu_busy,
    output logic [ADDR_W-1:0] o_ext_eep_addr,
    output logic [7:0]        o_ext_eep_data_in,
    output logic              o_ext_eep_data_wr,
    output logic              o_ext_eep_data_rd,
    output logic              o_ext_eep_data_en,
    input  logic [7:0]        i_ext_eep_data_out,
    output logic              o_busy
);

    localparam int unsigned CNT_W = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;

    eep_state_e       r_state, w_state_d;
    eep_req_t         r_req, w_req_d, w_sel;
    logic             r_owner, w_owner_d;
    logic [1:0]       r_gnt, w_gnt_d;
    logic [1:0]       r_ack, w_ack_d;
    logic             r_en, w_en_d;
    logic             r_rd, w_rd_d;
    logic             r_wr, w_wr_d;
    logic [7:0]       r_rdata, w_rdata_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_busy;
    logic             w_pick_vld, w_pick, w_upd;

    eep_rr_arb2 #(
        .PRIO_FIX (PRIO_FIX)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_rq_req),
        .i_upd    (w_upd),
        .i_served (r_owner),
        .o_vld    (w_pick_vld),
        .o_idx    (w_pick)
    );

    // Request fields are carried at package width; narrower ADDR_W is zero-extended.
    always_comb begin
        w_sel.we    = w_pick ? i_rq_we[1] : i_rq_we[0];
        w_sel.addr  = w_pick ? EEP_ADDR_W'(i_rq_addr1) : EEP_ADDR_W'(i_rq_addr0);
        w_sel.wdata = w_pick ? i_rq_wdata1 : i_rq_wdata0;
    end

    always_comb begin
        w_state_d = r_state;
        w_req_d   = r_req;
        w_owner_d = r_owner;
        w_gnt_d   = r_gnt;
        w_ack_d   = 2'b00;
        w_en_d    = r_en;
        w_rd_d    = 1'b0;
        w_wr_d    = 1'b0;
        w_rdata_d = r_rdata;
        w_cnt_d   = r_cnt;
        w_upd     = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_gnt_d = 2'b00;
                // The ack cycle is dead time so the served requester can drop its request.
                if (!i_cpu_busy && w_pick_vld && (r_ack == 2'b00)) begin
                    w_state_d = StSetup;
                    w_req_d   = w_sel;
                    w_owner_d = w_pick;
                    w_gnt_d   = w_pick ? 2'b10 : 2'b01;
                    w_en_d    = 1'b1;
                end
            end
            StSetup: begin
                w_state_d = r_req.we ? StWr : StRdCap;
                w_rd_d    = ~r_req.we;
                w_wr_d    = r_req.we;
            end
            StRdCap: begin
                w_rdata_d = i_ext_eep_data_out;
                w_ack_d   = r_gnt;
                w_en_d    = 1'b0;
                w_upd     = 1'b1;
                w_state_d = StIdle;
            end
            StWr: begin
                w_ack_d = r_gnt;
                w_en_d  = 1'b0;
                w_upd   = 1'b1;
                if (WR_GAP == 0) begin
                    w_state_d = StIdle;
                end else begin
                    w_state_d = StGap;
                    w_cnt_d   = CNT_W'(WR_GAP);
                end
            end
            StGap: begin
                w_gnt_d = 2'b00;
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_req   <= '0;
            r_owner <= 1'b0;
            r_gnt   <= 2'b00;
            r_ack   <= 2'b00;
            r_en    <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rdata <= 8'h00;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_req   <= w_req_d;
            r_owner <= w_owner_d;
            r_gnt   <= w_gnt_d;
            r_ack   <= w_ack_d;
            r_en    <= w_en_d;
            r_rd    <= w_rd_d;
            r_wr    <= w_wr_d;
            r_rdata <= w_rdata_d;
            r_cnt   <= w_cnt_d;
            r_busy  <= (w_state_d != StIdle);
        end
    end

    assign o_rq_gnt          = r_gnt;
    assign o_rq_ack          = r_ack;
    assign o_rq_rdata        = r_rdata;
    assign o_ext_eep_addr    = ADDR_W'(r_req.addr);
    assign o_ext_eep_data_in = r_req.wdata;
    assign o_ext_eep_data_wr = r_wr;
    assign o_ext_eep_data_rd = r_rd;
    assign o_ext_eep_data_en = r_en;
    assign o_busy            = r_busy;

endmodule
